// File: rtl/mips_mem_pkg.sv
// Shared types and limits for the MIPS unified-memory arbiter.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_t;

  localparam int MEM_LAT_MAX    = 7;
  localparam int STARVE_MAX_MAX = 15;

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// Fetch port, data port and memory strobes shared between pipeline, arbiter and RAM.
interface mips_mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter: IF and DM share one RAM, one access at a time, ack after MEM_LAT+2 cycles.
// Requesters hold req until ack; DM has priority unless fetch has been passed over STARVE_MAX times.
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk1,
  input  logic               rst_n,
  input  logic               halt,
  mips_mem_arbiter_if.slave  bus,
  output logic               busy
);

  localparam logic [2:0] CNT_INIT   = 3'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              busy_q, busy_d;

  logic if_elig, dm_elig, pick_if;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    starve_cnt_d = starve_cnt_q;
    mem_en_d     = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_ack_d     = 1'b0;
    dm_ack_d     = 1'b0;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;

    if_elig = bus.if_req & ~halt;
    dm_elig = bus.dm_req;
    pick_if = if_elig & (~dm_elig | (starve_cnt_q == STARVE_LIM));

    case (state_q)
      IDLE: begin
        if (pick_if) begin
          owner_d      = OWN_IF;
          mem_addr_d   = bus.if_addr;
          mem_we_d     = 1'b0;
          starve_cnt_d = '0;
          mem_en_d     = 1'b1;
          state_d      = ISSUE;
        end else if (dm_elig) begin
          owner_d     = OWN_DM;
          mem_addr_d  = bus.dm_addr;
          mem_we_d    = bus.dm_we;
          mem_wdata_d = bus.dm_wdata;
          mem_en_d    = 1'b1;
          state_d     = ISSUE;
          // Only a DM win over a waiting fetch counts toward starvation.
          if (!if_elig)
            starve_cnt_d = '0;
          else if (starve_cnt_q != STARVE_LIM)
            starve_cnt_d = starve_cnt_q + 4'd1;
        end else begin
          starve_cnt_d = '0;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          if (owner_q == OWN_IF)
            if_rdata_d = bus.mem_rdata;
          else if (!mem_we_q)
            dm_rdata_d = bus.mem_rdata;
          if_ack_d = (owner_q == OWN_IF);
          dm_ack_d = (owner_q == OWN_DM);
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      cnt_q        <= '0;
      starve_cnt_q <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_ack_q     <= 1'b0;
      dm_ack_q     <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      starve_cnt_q <= starve_cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_ack_q     <= if_ack_d;
      dm_ack_q     <= dm_ack_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: directed vectors, corner sequences, and a randomized run against a transaction model.
module tb_mips_mem_arbiter;
  import mips_mem_pkg::*;

  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int SMAX = 4;
  localparam int L1   = 1;

  logic clk1  = 1'b0;
  logic rst_n = 1'b0;
  logic halt1 = 1'b0;
  logic halt3 = 1'b0;
  logic busy1, busy3;

  always #5 clk1 = ~clk1;

  mips_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
  mips_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b3 ();

  mips_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_MAX(SMAX)) u1 (
    .clk1(clk1), .rst_n(rst_n), .halt(halt1), .bus(b1.slave), .busy(busy1));
  mips_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .STARVE_MAX(SMAX)) u3 (
    .clk1(clk1), .rst_n(rst_n), .halt(halt3), .bus(b3.slave), .busy(busy3));

  // RAM models: read data is only valid exactly MEM_LAT cycles after mem_en.
  logic [31:0]      mem1 [0:1023];
  logic [31:0]      mem3 [0:1023];
  logic [31:0]      ref_mem [0:1023];
  logic             v1;
  logic [31:0]      pd1;
  logic [2:0]       v3;
  logic [2:0][31:0] pd3;

  always @(posedge clk1) begin
    v1 <= b1.mem_en && !b1.mem_we;
    if (b1.mem_en) begin
      if (b1.mem_we) mem1[b1.mem_addr] <= b1.mem_wdata;
      else           pd1 <= mem1[b1.mem_addr];
    end
    v3 <= {v3[1:0], b3.mem_en && !b3.mem_we};
    pd3 <= {pd3[1:0], mem3[b3.mem_addr]};
    if (b3.mem_en && b3.mem_we) mem3[b3.mem_addr] <= b3.mem_wdata;
  end
  assign b1.mem_rdata = v1    ? pd1    : 32'hBAD0_BAD0;
  assign b3.mem_rdata = v3[2] ? pd3[2] : 32'hBAD0_BAD0;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clr1();
    b1.if_req = 1'b0; b1.dm_req = 1'b0; b1.dm_we = 1'b0; halt1 = 1'b0;
  endtask

  typedef struct {
    logic        ifr;
    logic [9:0]  ia;
    logic        dmr;
    logic        we;
    logic [9:0]  da;
    logic [31:0] wd;
    logic        own_dm;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt [8];

  // Single access on u1 starting from IDLE; request driven in cycle 0.
  task automatic run_txn(input int idx, input vec_t v);
    int en_n = 0, en_c = -1, wr_n = 0, ifa_n = 0, ifa_c = -1, dma_n = 0, dma_c = -1;
    int busy_n = 0, addr_bad = 0;
    logic [9:0] exp_a;
    exp_a = v.own_dm ? v.da : v.ia;
    b1.if_req = v.ifr; b1.if_addr = v.ia;
    b1.dm_req = v.dmr; b1.dm_we = v.we; b1.dm_addr = v.da; b1.dm_wdata = v.wd;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk1);
      if (b1.mem_en) begin en_n++; en_c = c; end
      if (b1.mem_en && b1.mem_we) wr_n++;
      if (c <= 3 && b1.mem_addr !== exp_a) addr_bad++;
      if (busy1) busy_n++;
      if (b1.if_ack) begin ifa_n++; ifa_c = c; end
      if (b1.dm_ack) begin dma_n++; dma_c = c; end
      if (b1.if_ack || b1.dm_ack) begin b1.if_req = 1'b0; b1.dm_req = 1'b0; end
    end
    chk($sformatf("v%0d_en_count", idx), 32'(en_n), 32'd1);
    chk($sformatf("v%0d_en_cycle", idx), 32'(en_c), 32'd1);
    chk($sformatf("v%0d_write_strobes", idx), 32'(wr_n), 32'(v.own_dm && v.we));
    chk($sformatf("v%0d_addr_hold", idx), 32'(addr_bad), 32'd0);
    chk($sformatf("v%0d_busy_cycles", idx), 32'(busy_n), 32'd3);
    if (v.own_dm) begin
      chk($sformatf("v%0d_dm_ack_cycle", idx), 32'(dma_c), 32'd3);
      chk($sformatf("v%0d_acks", idx), 32'(dma_n * 16 + ifa_n), 32'd16);
      chk($sformatf("v%0d_dm_rdata", idx), b1.dm_rdata, v.exp_rd);
    end else begin
      chk($sformatf("v%0d_if_ack_cycle", idx), 32'(ifa_c), 32'd3);
      chk($sformatf("v%0d_acks", idx), 32'(dma_n * 16 + ifa_n), 32'd1);
      chk($sformatf("v%0d_if_rdata", idx), b1.if_rdata, v.exp_rd);
    end
  endtask

  int          en_n, en_c, ack_c, addr_bad, busy_n, cnt, s, g;
  logic        exp_if, act, o_dm, ewe, exp_en, exp_ia, exp_da, exp_bz, ife, dme, ifdone, dmdone;
  logic [9:0]  ea;
  logic [31:0] erd, last_if, last_dm;
  int          k;

  initial begin
    b1.if_req = 0; b1.if_addr = 0; b1.dm_req = 0; b1.dm_we = 0; b1.dm_addr = 0; b1.dm_wdata = 0;
    b3.if_req = 0; b3.if_addr = 0; b3.dm_req = 0; b3.dm_we = 0; b3.dm_addr = 0; b3.dm_wdata = 0;
    for (int i = 0; i < 1024; i++) begin
      mem1[i] <= {22'h0, 10'(i)} ^ 32'h5A5A_0000;
      mem3[i] <= {22'h0, 10'(i)} ^ 32'h3C3C_0000;
    end
    mem1[5]      <= 32'h2821_0001;
    mem1[10'h3FF] <= 32'hCAFE_F00D;
    mem3[10'h3FF] <= 32'hA5A5_0FF0;

    //            ifr  ia      dmr  we   da      wd             own_dm exp_rd
    vt[0] = '{1'b1, 10'h005, 1'b0, 1'b0, 10'h000, 32'h0,        1'b0, 32'h2821_0001};
    vt[1] = '{1'b0, 10'h000, 1'b1, 1'b1, 10'h040, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000};
    vt[2] = '{1'b0, 10'h000, 1'b1, 1'b0, 10'h040, 32'h0,        1'b1, 32'hDEAD_BEEF};
    vt[3] = '{1'b1, 10'h3FF, 1'b1, 1'b0, 10'h040, 32'h0,        1'b1, 32'hDEAD_BEEF};
    vt[4] = '{1'b1, 10'h3FF, 1'b0, 1'b0, 10'h000, 32'h0,        1'b0, 32'hCAFE_F00D};
    vt[5] = '{1'b0, 10'h000, 1'b1, 1'b1, 10'h000, 32'h1357_9BDF, 1'b1, 32'hDEAD_BEEF};
    vt[6] = '{1'b1, 10'h000, 1'b0, 1'b0, 10'h000, 32'h0,        1'b0, 32'h1357_9BDF};
    vt[7] = '{1'b0, 10'h000, 1'b1, 1'b0, 10'h3FF, 32'h0,        1'b1, 32'hCAFE_F00D};

    // Reset values
    @(negedge clk1);
    chk("rst_ctl", 32'({b1.mem_en, b1.mem_we, b1.if_ack, b1.dm_ack, busy1}), 32'd0);
    chk("rst_addr_wdata", 32'(b1.mem_addr) | b1.mem_wdata, 32'd0);
    chk("rst_rdata", b1.if_rdata | b1.dm_rdata, 32'd0);
    chk("rst_ctl_lat3", 32'({b3.mem_en, b3.mem_we, b3.if_ack, b3.dm_ack, busy3}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk1);
    chk("post_rst_idle", 32'({b1.mem_en, busy1}), 32'd0);

    for (int i = 0; i < 8; i++) run_txn(i, vt[i]);

    // Halt blocks fetch grants; halt raised in flight does not abort
    halt1 = 1'b1; b1.if_req = 1'b1; b1.if_addr = 10'h005;
    cnt = 0;
    repeat (20) begin @(negedge clk1); if (b1.mem_en || busy1) cnt++; end
    chk("halt_block", 32'(cnt), 32'd0);
    halt1 = 1'b0;
    en_n = 0; en_c = -1; ack_c = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk1);
      if (b1.mem_en) begin en_n++; en_c = c; end
      if (b1.if_ack) ack_c = c;
      if (c == 1) halt1 = 1'b1;
    end
    chk("halt_release_en_cycle", 32'(en_c), 32'd1);
    chk("halt_inflight_ack_cycle", 32'(ack_c), 32'd3);
    chk("halt_inflight_rdata", b1.if_rdata, 32'h2821_0001);
    chk("halt_no_regrant", 32'(en_n), 32'd1);
    clr1();
    @(negedge clk1);

    // DM drops req right after its grant; access still completes
    b1.dm_req = 1'b1; b1.dm_we = 1'b0; b1.dm_addr = 10'h005;
    ack_c = -1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk1);
      if (c == 1) b1.dm_req = 1'b0;
      if (b1.dm_ack) ack_c = c;
    end
    chk("drop_ack_cycle", 32'(ack_c), 32'd3);
    chk("drop_rdata", b1.dm_rdata, 32'h2821_0001);

    // MEM_LAT=3 load from the top address
    b3.dm_req = 1'b1; b3.dm_we = 1'b0; b3.dm_addr = 10'h3FF;
    en_c = -1; ack_c = -1; addr_bad = 0; busy_n = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk1);
      if (b3.mem_en) en_c = c;
      if (c <= 5 && b3.mem_addr !== 10'h3FF) addr_bad++;
      if (busy3) busy_n++;
      if (b3.dm_ack) begin ack_c = c; b3.dm_req = 1'b0; end
    end
    chk("lat3_en_cycle", 32'(en_c), 32'd1);
    chk("lat3_ack_cycle", 32'(ack_c), 32'd5);
    chk("lat3_addr_hold", 32'(addr_bad), 32'd0);
    chk("lat3_busy_cycles", 32'(busy_n), 32'd5);
    chk("lat3_rdata", b3.dm_rdata, 32'hA5A5_0FF0);

    // Starvation: both requesters always pending
    b1.if_req = 1'b1; b1.if_addr = 10'h010;
    b1.dm_req = 1'b1; b1.dm_we = 1'b0; b1.dm_addr = 10'h100;
    s = 0; g = 0; cnt = 0;
    while (g < 10 && cnt < 120) begin
      @(negedge clk1);
      cnt++;
      if (b1.mem_en) begin
        exp_if = (s == SMAX);
        s = exp_if ? 0 : s + 1;
        chk($sformatf("starve_grant%0d_is_if", g), 32'(b1.mem_addr == 10'h010), 32'(exp_if));
        g++;
      end
      if (b1.dm_ack) b1.dm_addr = b1.dm_addr + 10'd1;
    end
    if (g < 10) chk("starve_timeout", 32'(g), 32'd10);
    clr1();
    repeat (8) @(negedge clk1);

    // Reset during WAIT
    b1.dm_req = 1'b1; b1.dm_we = 1'b0; b1.dm_addr = 10'h040;
    repeat (2) @(negedge clk1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ctl", 32'({b1.mem_en, b1.mem_we, b1.if_ack, b1.dm_ack, busy1}), 32'd0);
    chk("rst_mid_addr", 32'(b1.mem_addr), 32'd0);
    chk("rst_mid_rdata", b1.dm_rdata | b1.if_rdata, 32'd0);
    clr1();
    cnt = 0;
    repeat (2) begin @(negedge clk1); if (b1.dm_ack || b1.if_ack) cnt++; end
    rst_n = 1'b1;
    repeat (6) begin @(negedge clk1); if (b1.dm_ack || b1.if_ack || b1.mem_en) cnt++; end
    chk("rst_mid_no_ack", 32'(cnt), 32'd0);
    run_txn(8, vt[2]);

    // Randomized traffic against a transaction-level model
    rst_n = 1'b0;
    @(negedge clk1);
    rst_n = 1'b1;
    for (int i = 0; i < 1024; i++) ref_mem[i] = mem1[i];
    act = 0; k = 0; s = 0; o_dm = 0; ewe = 0; ea = 0; erd = 0; last_if = 0; last_dm = 0;
    repeat (800) begin
      @(negedge clk1);
      ifdone = 0; dmdone = 0;
      if (act) k++;
      exp_en = act && (k == 1);
      exp_ia = act && (k == L1 + 2) && !o_dm;
      exp_da = act && (k == L1 + 2) && o_dm;
      exp_bz = act && (k >= 1) && (k <= L1 + 2);
      chk("rnd_ctl", 32'({b1.mem_en, b1.if_ack, b1.dm_ack, busy1}),
          32'({exp_en, exp_ia, exp_da, exp_bz}));
      if (exp_en) begin
        chk("rnd_addr_we", 32'({b1.mem_we, b1.mem_addr}), 32'({ewe, ea}));
        if (ewe) chk("rnd_wdata", b1.mem_wdata, b1.dm_wdata);
      end
      if (exp_ia) begin last_if = erd; chk("rnd_if_rdata", b1.if_rdata, last_if); ifdone = 1; end
      if (exp_da) begin
        if (!ewe) last_dm = erd;
        chk("rnd_dm_rdata", b1.dm_rdata, last_dm);
        dmdone = 1;
      end
      if (act && k == L1 + 3) act = 0;

      if (ifdone) b1.if_req = 1'b0;
      if (dmdone) b1.dm_req = 1'b0;
      if (!b1.if_req && $urandom_range(3) == 0) begin
        b1.if_req = 1'b1; b1.if_addr = 10'($urandom_range(63));
      end
      if (!b1.dm_req && $urandom_range(2) == 0) begin
        b1.dm_req = 1'b1; b1.dm_we = 1'($urandom_range(1));
        b1.dm_addr = 10'($urandom_range(63)); b1.dm_wdata = $urandom;
      end
      if ($urandom_range(7) == 0) halt1 = ~halt1;

      if (!act) begin
        ife = b1.if_req && !halt1;
        dme = b1.dm_req;
        if (ife && (!dme || s == SMAX)) begin
          act = 1; k = 0; o_dm = 0; ewe = 0; ea = b1.if_addr; erd = ref_mem[ea]; s = 0;
        end else if (dme) begin
          act = 1; k = 0; o_dm = 1; ewe = b1.dm_we; ea = b1.dm_addr;
          if (ewe) ref_mem[ea] = b1.dm_wdata;
          else     erd = ref_mem[ea];
          s = ife ? ((s < SMAX) ? s + 1 : SMAX) : 0;
        end else begin
          s = 0;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
